// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - dump stream and processor read-port bundle for run_controller
interface run_controller_if #(
    parameter int DATA_W = 32
);
    logic [5:0]        mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [4:0]        reg_raddr;
    logic [DATA_W-1:0] reg_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_sel;
    logic [5:0]        dump_idx;

    modport master (
        output mem_raddr,
        input  mem_rdata,
        output reg_raddr,
        input  reg_rdata,
        output dump_valid,
        input  dump_ready,
        output dump_data,
        output dump_sel,
        output dump_idx
    );

    modport slave (
        input  mem_raddr,
        output mem_rdata,
        input  reg_raddr,
        output reg_rdata,
        input  dump_valid,
        output dump_ready,
        input  dump_data,
        input  dump_sel,
        input  dump_idx
    );
endinterface

// File: rtl/run_controller.sv
// rtl/run_controller.sv - processor run/dump sequencer: reset, bounded run, memory then register dump
module run_controller #(
    parameter int MAX_CYCLES   = 32,
    parameter int RESET_CYCLES = 1,
    parameter int MEM_WORDS    = 64,
    parameter int REG_COUNT    = 32,
    parameter int DATA_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt,
    output logic                cpu_reset,
    output logic                cpu_en,
    output logic [15:0]         cycle_count,
    output logic                busy,
    output logic                done,
    run_controller_if.master    dump_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DUMP_MEM,
        S_DUMP_REG,
        S_DONE
    } state_t;

    localparam logic [15:0] MAX_C    = 16'(MAX_CYCLES);
    localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [5:0]  MEM_LAST = 6'(MEM_WORDS - 1);
    localparam logic [5:0]  REG_LAST = 6'(REG_COUNT - 1);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic [15:0] cnt_inc;
    logic [DATA_W-1:0] data_sel;

    // State, beat index, run counter and reset hold counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Next-state: start only honoured when parked; idx returns to 0 between the two dump phases
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        cnt_inc = cnt_q + 16'd1;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    rcnt_d  = RST_LAST;
                end
            end
            S_RESET: begin
                if (rcnt_q == 16'd0) state_d = S_RUN;
                else                 rcnt_d  = rcnt_q - 16'd1;
            end
            S_RUN: begin
                // halt cycle counts; halt and max in the same cycle is one exit
                cnt_d = cnt_inc;
                if (cnt_inc == MAX_C || halt) state_d = S_DUMP_MEM;
            end
            S_DUMP_MEM: begin
                if (dump_if.dump_ready) begin
                    if (idx_q == MEM_LAST) begin
                        idx_d   = '0;
                        state_d = S_DUMP_REG;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_DUMP_REG: begin
                if (dump_if.dump_ready) begin
                    if (idx_q == REG_LAST) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; dump payload is the same-cycle async read data
    always_comb begin
        data_sel = (state_q == S_DUMP_REG) ? dump_if.reg_rdata : dump_if.mem_rdata;
        cpu_reset          = (state_q == S_IDLE) || (state_q == S_RESET);
        cpu_en             = (state_q == S_RUN);
        busy               = (state_q == S_RESET) || (state_q == S_RUN) ||
                             (state_q == S_DUMP_MEM) || (state_q == S_DUMP_REG);
        done               = (state_q == S_DONE);
        cycle_count        = cnt_q;
        dump_if.dump_valid = (state_q == S_DUMP_MEM) || (state_q == S_DUMP_REG);
        dump_if.dump_sel   = (state_q == S_DUMP_REG);
        dump_if.dump_idx   = idx_q;
        dump_if.mem_raddr  = idx_q;
        dump_if.reg_raddr  = idx_q[4:0];
        dump_if.dump_data  = data_sel;
    end

endmodule
